// File: rtl/alu_sequencer.sv
// Sequences 32-bit and 64-bit ALU commands over a shared 32-bit external ALU.
// 64-bit ops run low half, high half, then an optional +/-1 carry-propagation pass.
module alu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_r,
    input  logic        alu_z,
    input  logic        alu_c,
    input  logic        alu_v,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_r,
    output logic        rsp_z,
    output logic        rsp_c,
    output logic        rsp_v
);

    typedef enum logic [2:0] {IDLE, P1, P2, P3, RESP} state_t;

    typedef enum logic [2:0] {
        CMD_AND   = 3'b000,
        CMD_OR    = 3'b001,
        CMD_ADD   = 3'b010,
        CMD_SUB   = 3'b011,
        CMD_SLT   = 3'b100,
        CMD_NOR   = 3'b101,
        CMD_ADD64 = 3'b110,
        CMD_SUB64 = 3'b111
    } cmd_t;

    function automatic logic [3:0] alu_code(input cmd_t cmd);
        case (cmd)
            CMD_AND:            alu_code = 4'b0000;
            CMD_OR:             alu_code = 4'b0001;
            CMD_ADD, CMD_ADD64: alu_code = 4'b0010;
            CMD_SUB, CMD_SUB64: alu_code = 4'b0110;
            CMD_SLT:            alu_code = 4'b0111;
            default:            alu_code = 4'b1100;
        endcase
    endfunction

    function automatic logic ovf64(input logic sub, input logic a63, input logic b63,
                                   input logic r63);
        ovf64 = (sub ? (a63 != b63) : (a63 == b63)) && (r63 != a63);
    endfunction

    state_t      state_q, state_d;
    cmd_t        cmd_q, cmd_d;
    logic [31:0] a_hi_q, a_hi_d;
    logic [31:0] b_hi_q, b_hi_d;
    logic [31:0] lo_q, lo_d;
    logic        carry0_q, carry0_d;
    logic        carry1_q, carry1_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic [63:0] rsp_r_q, rsp_r_d;
    logic        rsp_z_q, rsp_z_d;
    logic        rsp_c_q, rsp_c_d;
    logic        rsp_v_q, rsp_v_d;

    logic is64;
    logic arith32;

    assign is64    = (cmd_q[2:1] == 2'b11);
    assign arith32 = (cmd_q[2:1] == 2'b01);

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        a_hi_d   = a_hi_q;
        b_hi_d   = b_hi_q;
        lo_d     = lo_q;
        carry0_d = carry0_q;
        carry1_d = carry1_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        rsp_r_d  = rsp_r_q;
        rsp_z_d  = rsp_z_q;
        rsp_c_d  = rsp_c_q;
        rsp_v_d  = rsp_v_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d  = P1;
                    cmd_d    = cmd_t'(req_op);
                    a_hi_d   = req_a[63:32];
                    b_hi_d   = req_b[63:32];
                    carry0_d = 1'b0;
                    carry1_d = 1'b0;
                    alu_a_d  = req_a[31:0];
                    alu_b_d  = req_b[31:0];
                    alu_op_d = alu_code(cmd_t'(req_op));
                end
            end
            P1: begin
                lo_d     = alu_r;
                carry0_d = alu_c;
                if (is64) begin
                    state_d = P2;
                    alu_a_d = a_hi_q;
                    alu_b_d = b_hi_q;
                end else begin
                    state_d  = RESP;
                    alu_a_d  = '0;
                    alu_b_d  = '0;
                    alu_op_d = '0;
                    rsp_r_d  = {32'd0, alu_r};
                    rsp_z_d  = alu_z;
                    rsp_c_d  = arith32 & alu_c;
                    rsp_v_d  = arith32 & alu_v;
                end
            end
            P2: begin
                carry1_d = alu_c;
                if (carry0_q) begin
                    // the high word rides in alu_a_q into the +/-1 pass
                    state_d = P3;
                    alu_a_d = alu_r;
                    alu_b_d = 32'd1;
                end else begin
                    state_d  = RESP;
                    alu_a_d  = '0;
                    alu_b_d  = '0;
                    alu_op_d = '0;
                    rsp_r_d  = {alu_r, lo_q};
                    rsp_z_d  = ({alu_r, lo_q} == '0);
                    rsp_c_d  = alu_c;
                    rsp_v_d  = ovf64(cmd_q[0], a_hi_q[31], b_hi_q[31], alu_r[31]);
                end
            end
            P3: begin
                // carry2 is folded straight into the response flag
                state_d  = RESP;
                alu_a_d  = '0;
                alu_b_d  = '0;
                alu_op_d = '0;
                rsp_r_d  = {alu_r, lo_q};
                rsp_z_d  = ({alu_r, lo_q} == '0);
                rsp_c_d  = carry1_q | alu_c;
                rsp_v_d  = ovf64(cmd_q[0], a_hi_q[31], b_hi_q[31], alu_r[31]);
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cmd_q    <= CMD_AND;
            a_hi_q   <= '0;
            b_hi_q   <= '0;
            lo_q     <= '0;
            carry0_q <= 1'b0;
            carry1_q <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            rsp_r_q  <= '0;
            rsp_z_q  <= 1'b0;
            rsp_c_q  <= 1'b0;
            rsp_v_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            a_hi_q   <= a_hi_d;
            b_hi_q   <= b_hi_d;
            lo_q     <= lo_d;
            carry0_q <= carry0_d;
            carry1_q <= carry1_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            rsp_r_q  <= rsp_r_d;
            rsp_z_q  <= rsp_z_d;
            rsp_c_q  <= rsp_c_d;
            rsp_v_q  <= rsp_v_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_v     = rsp_v_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: external ALU model, abstract 64-bit arithmetic reference,
// per-cycle output comparison, directed corner cases and randomized traffic.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [2:0]  req_op = '0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic        req_ready, rsp_valid;
    logic [31:0] alu_a, alu_b, alu_r;
    logic [3:0]  alu_op;
    logic        alu_z, alu_c, alu_v;
    logic [63:0] rsp_r;
    logic        rsp_z, rsp_c, rsp_v;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_r(alu_r), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_r(rsp_r),
        .rsp_z(rsp_z), .rsp_c(rsp_c), .rsp_v(rsp_v)
    );

    // External ALU; logic ops report c=v=1 so the sequencer must mask them.
    logic [32:0] alu_w;
    always_comb begin
        alu_w = '0;
        alu_r = 32'hDEADBEEF;
        alu_c = 1'b1;
        alu_v = 1'b1;
        case (alu_op)
            4'b0000: alu_r = alu_a & alu_b;
            4'b0001: alu_r = alu_a | alu_b;
            4'b0010: begin
                alu_w = {1'b0, alu_a} + {1'b0, alu_b};
                alu_r = alu_w[31:0];
                alu_c = alu_w[32];
                alu_v = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
            4'b0110: begin
                alu_r = alu_a - alu_b;
                alu_c = alu_a < alu_b;
                alu_v = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
            4'b0111: alu_r = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'b1100: alu_r = ~(alu_a | alu_b);
            default: ;
        endcase
        alu_z = (alu_r == '0);
    end

    typedef struct {
        logic [63:0] r;
        logic        z, c, v;
        int unsigned lat;
    } exp_t;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    function automatic exp_t ref_model(input logic [2:0] op, input logic [63:0] a,
                                       input logic [63:0] b);
        exp_t e;
        logic [31:0] a32, b32;
        longint sa, sb, s;
        logic [64:0] w;
        logic [32:0] w33;
        a32 = a[31:0];
        b32 = b[31:0];
        sa = $signed(a32);
        sb = $signed(b32);
        w33 = {1'b0, a32} + {1'b0, b32};
        e.c = 1'b0;
        e.v = 1'b0;
        e.lat = 2;
        case (op)
            3'd0: e.r = {32'd0, a32 & b32};
            3'd1: e.r = {32'd0, a32 | b32};
            3'd2: begin
                e.r = {32'd0, a32 + b32};
                e.c = w33[32];
                s = sa + sb;
                e.v = (s > SMAX) || (s < SMIN);
            end
            3'd3: begin
                e.r = {32'd0, a32 - b32};
                e.c = a32 < b32;
                s = sa - sb;
                e.v = (s > SMAX) || (s < SMIN);
            end
            3'd4: e.r = (sa < sb) ? 64'd1 : 64'd0;
            3'd5: e.r = {32'd0, ~(a32 | b32)};
            3'd6: begin
                w = {1'b0, a} + {1'b0, b};
                e.r = w[63:0];
                e.c = w[64];
                e.v = (a[63] == b[63]) && (e.r[63] != a[63]);
                e.lat = w33[32] ? 4 : 3;
            end
            default: begin
                e.r = a - b;
                e.c = a < b;
                e.v = (a[63] != b[63]) && (e.r[63] != a[63]);
                e.lat = (a32 < b32) ? 4 : 3;
            end
        endcase
        e.z = (e.r == 64'd0);
        return e;
    endfunction

    function automatic logic [3:0] code_of(input logic [2:0] op);
        case (op)
            3'd0:       code_of = 4'b0000;
            3'd1:       code_of = 4'b0001;
            3'd2, 3'd6: code_of = 4'b0010;
            3'd3, 3'd7: code_of = 4'b0110;
            3'd4:       code_of = 4'b0111;
            default:    code_of = 4'b1100;
        endcase
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        $display("FAIL %s: got timeout expected handshake at %0t", name, $time);
    endtask

    // Reference state: one command in flight, age = edges since the accept edge.
    bit          known = 0;
    bit          busy = 0;
    int unsigned age = 0;
    exp_t        cur;
    logic [2:0]  cur_op = '0;
    logic [63:0] cur_a = '0, cur_b = '0;
    logic [63:0] last_r = '0;
    logic [2:0]  last_zcv = '0;
    logic        in_resp;

    always @(posedge clk) begin
        if (!rst_n) begin
            known = 1;
            busy = 0;
            age = 0;
            last_r = '0;
            last_zcv = '0;
        end else if (!busy) begin
            if (req_valid) begin
                busy = 1;
                age = 0;
                cur_op = req_op;
                cur_a = req_a;
                cur_b = req_b;
                cur = ref_model(req_op, req_a, req_b);
            end
        end else if ((age + 1 >= cur.lat) && rsp_ready) begin
            busy = 0;
            last_r = cur.r;
            last_zcv = {cur.z, cur.c, cur.v};
        end else begin
            age++;
        end
    end

    function automatic logic [67:0] exp_alu();
        logic [31:0] hi;
        hi = cur_op[0] ? (cur_a[63:32] - cur_b[63:32]) : (cur_a[63:32] + cur_b[63:32]);
        if (!busy || (age + 1 >= cur.lat)) return '0;
        case (age)
            0:       return {cur_a[31:0], cur_b[31:0], code_of(cur_op)};
            1:       return {cur_a[63:32], cur_b[63:32], code_of(cur_op)};
            default: return {hi, 32'd1, code_of(cur_op)};
        endcase
    endfunction

    always @(negedge clk) begin
        if (known) begin
            in_resp = busy && (age + 1 >= cur.lat);
            chk("req_ready", req_ready, !busy);
            chk("rsp_valid", rsp_valid, in_resp);
            if (in_resp) begin
                chk("rsp_r", rsp_r, cur.r);
                chk("rsp_zcv", {rsp_z, rsp_c, rsp_v}, {cur.z, cur.c, cur.v});
            end else if (!busy) begin
                chk("rsp_r_hold", rsp_r, last_r);
                chk("rsp_zcv_hold", {rsp_z, rsp_c, rsp_v}, last_zcv);
            end
            chk("alu_drive", {alu_a, alu_b, alu_op}, exp_alu());
        end
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        output bit ok);
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            fail_timeout("accept");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic directed(input string name, input logic [2:0] op, input logic [63:0] a,
                            input logic [63:0] b, input logic [63:0] exp_r,
                            input logic [2:0] exp_zcv, input int unsigned lat,
                            input int unsigned hold);
        exp_t e;
        bit ok;
        int unsigned n;
        e = ref_model(op, a, b);
        chk({name, "_model_r"}, e.r, exp_r);
        chk({name, "_model_zcv"}, {e.z, e.c, e.v}, exp_zcv);
        chk({name, "_model_lat"}, e.lat, lat);
        rsp_ready = 1'b0;
        send(op, a, b, ok);
        if (!ok) return;
        req_valid = (hold != 0);
        req_op = 3'd7;
        req_a = '1;
        req_b = '1;
        n = 0;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            fail_timeout({name, "_rsp"});
            return;
        end
        chk({name, "_latency"}, n + 1, lat);
        chk({name, "_r"}, rsp_r, exp_r);
        chk({name, "_zcv"}, {rsp_z, rsp_c, rsp_v}, exp_zcv);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk({name, "_stall_r"}, rsp_r, exp_r);
            chk({name, "_stall_valid"}, rsp_valid, 1'b1);
            chk({name, "_stall_ready"}, req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk({name, "_idle_ready"}, req_ready, 1'b1);
        chk({name, "_idle_r"}, rsp_r, exp_r);
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        bit ok;
        bit got;
        send(op, a, b, ok);
        if (!ok) return;
        got = 0;
        for (int k = 0; k < 40; k++) begin
            rsp_ready = 1'($urandom_range(0, 1));
            req_valid = 1'($urandom_range(0, 1));
            req_op = 3'($urandom_range(0, 7));
            req_a = {$urandom, $urandom};
            req_b = {$urandom, $urandom};
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                got = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!got) fail_timeout("random_rsp");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h00000000_FFFFFFFF;
            3:       return 64'h7FFFFFFF_7FFFFFFF;
            4:       return 64'h80000000_80000000;
            5:       return {$urandom, 32'hFFFFFFFF};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        bit ok;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp", {rsp_r, rsp_z, rsp_c, rsp_v}, '0);
        chk("reset_alu", {alu_a, alu_b, alu_op}, '0);
        @(posedge clk);
        #1;

        directed("add_ovf", 3'd2, 64'h7FFFFFFF, 64'h1, 64'h00000000_80000000, 3'b001, 2, 0);
        directed("add64_c0", 3'd6, 64'h00000000_FFFFFFFF, 64'h1, 64'h00000001_00000000,
                 3'b000, 4, 0);
        directed("sub64_brw", 3'd7, 64'h0, 64'h1, 64'hFFFFFFFF_FFFFFFFF, 3'b010, 4, 0);
        directed("add64_wrap", 3'd6, 64'hFFFFFFFF_FFFFFFFF, 64'h1, 64'h0, 3'b110, 4, 0);
        directed("and_mask", 3'd0, 64'hF0, 64'h0F, 64'h0, 3'b100, 2, 0);
        directed("sub_stall", 3'd3, 64'h5, 64'h7, 64'h00000000_FFFFFFFE, 3'b010, 2, 5);
        directed("slt_neg", 3'd4, 64'hFFFFFFFF, 64'h1, 64'h1, 3'b000, 2, 0);
        directed("add64_noc", 3'd6, 64'h00000001_00000002, 64'h00000003_00000004,
                 64'h00000004_00000006, 3'b000, 3, 0);

        // Reset while the ADD64 is in its high-half pass.
        send(3'd6, 64'h12345678_FFFFFFFF, 64'h1, ok);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abandon_valid", rsp_valid, 1'b0);
            chk("abandon_ready", req_ready, 1'b1);
            chk("abandon_rsp", {rsp_r, rsp_z, rsp_c, rsp_v}, '0);
        end
        @(posedge clk);
        #1;
        directed("add_post_rst", 3'd2, 64'h5, 64'h7, 64'hC, 3'b000, 2, 0);

        for (int i = 0; i < 300; i++) begin
            run_cmd(3'($urandom_range(0, 7)), pick(), pick());
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1);
    end

endmodule
